// File: rtl/avmm_mem_resp_pkg.sv
// Shared definitions for the Avalon-MM memory responder: response codes,
// FSM state encoding and the backpressure LFSR tap mask.
package avmm_mem_resp_pkg;

    localparam logic [1:0] RESP_OKAY      = 2'b00;
    localparam logic [1:0] RESP_DECODEERR = 2'b11;

    // Fibonacci LFSR taps 16,14,13,11 expressed as a bit mask over lfsr[15:0].
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WR_BURST = 2'd1,
        RD_BURST = 2'd2
    } t_resp_state;

endpackage

// File: rtl/avmm_mem_resp_ram.sv
// Single-clock 1W/1R synchronous RAM, 1-cycle read latency.
// A read and a write to the same address in one cycle return the old data.
module avmm_mem_resp_ram #(
    parameter int DEPTH_LOG2 = 10,
    parameter int WIDTH      = 64
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [DEPTH_LOG2-1:0] waddr_i,
    input  logic [WIDTH-1:0]      wdata_i,
    input  logic [DEPTH_LOG2-1:0] raddr_i,
    output logic [WIDTH-1:0]      rdata_o
);

    logic [WIDTH-1:0] mem [2**DEPTH_LOG2];

    // Write port and registered read port share one clock edge.
    // NOTE: non-blocking assignments make the read sample mem before this
    // edge's write lands, which is exactly the old-data collision behaviour.
    // NOTE: no reset here on purpose; a resettable array cannot map to block RAM.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
        rdata_o <= mem[raddr_i];
    end

endmodule

// File: rtl/avmm_mem_responder.sv
// Avalon-MM slave memory model: 64-bit word-addressed RAM serving single and
// burst reads/writes, flagging beats beyond the RAM depth with DECODEERROR.
// Optional random backpressure: define AVMM_MEM_RESP_BACKPRESSURE_EN.
module avmm_mem_responder
    import avmm_mem_resp_pkg::*;
#(
    parameter int          DEPTH_LOG2  = 10,
    parameter int          ADDR_WIDTH  = 32,
    parameter int          BURST_WIDTH = 12,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic                   Clk_400,
    input  logic                   SoftReset_n,
    input  logic [ADDR_WIDTH-1:0]  avs_address,
    input  logic [BURST_WIDTH-1:0] avs_burstcount,
    input  logic                   avs_read,
    input  logic                   avs_write,
    input  logic [63:0]            avs_writedata,
    output logic                   avs_waitrequest,
    output logic [63:0]            avs_readdata,
    output logic                   avs_readdatavalid,
    output logic [1:0]             avs_response,
    output logic                   busy
);

    t_resp_state            state_q, state_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [BURST_WIDTH-1:0] remaining_q, remaining_d;
    logic [BURST_WIDTH-1:0] eff_count;
    logic                   rd_issue_q, rd_issue_d;
    logic                   rd_err_q, rd_err_d;
    logic                   rvalid_q;
    logic [63:0]            rdata_q;
    logic [1:0]             resp_q;
    logic                   stall;

    logic                   ram_we;
    logic [DEPTH_LOG2-1:0]  ram_waddr, ram_raddr;
    logic [63:0]            ram_wdata, ram_rdata;

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return (a >> DEPTH_LOG2) == '0;
    endfunction

    assign eff_count = (avs_burstcount == '0) ? BURST_WIDTH'(1) : avs_burstcount;

`ifdef AVMM_MEM_RESP_BACKPRESSURE_EN
    logic [15:0] lfsr_q;

    // Free-running LFSR; bit 0 drives the pseudo-random stall.
    always_ff @(posedge Clk_400 or negedge SoftReset_n) begin
        if (!SoftReset_n) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
        end
    end

    assign stall = lfsr_q[0];
`else
    assign stall = 1'b0;
`endif

    // Next-state, RAM port and waitrequest decode.
    // NOTE: every output gets a default first so no path leaves a latch.
    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        remaining_d     = remaining_q;
        rd_issue_d      = 1'b0;
        rd_err_d        = 1'b0;
        ram_we          = 1'b0;
        ram_waddr       = avs_address[DEPTH_LOG2-1:0];
        ram_wdata       = avs_writedata;
        ram_raddr       = addr_q[DEPTH_LOG2-1:0];
        avs_waitrequest = stall;

        unique case (state_q)
            IDLE: begin
                // Write wins when read and write arrive together.
                if (avs_write && !stall) begin
                    ram_we = in_range(avs_address);
                    if (eff_count != BURST_WIDTH'(1)) begin
                        state_d     = WR_BURST;
                        addr_d      = avs_address + 1'b1;
                        remaining_d = eff_count - 1'b1;
                    end
                end else if (avs_read && !stall) begin
                    state_d     = RD_BURST;
                    addr_d      = avs_address;
                    remaining_d = eff_count;
                end
            end
            WR_BURST: begin
                ram_waddr = addr_q[DEPTH_LOG2-1:0];
                if (avs_write && !stall) begin
                    ram_we      = in_range(addr_q);
                    addr_d      = addr_q + 1'b1;
                    remaining_d = remaining_q - 1'b1;
                    if (remaining_q == BURST_WIDTH'(1)) begin
                        state_d = IDLE;
                    end
                end
            end
            RD_BURST: begin
                avs_waitrequest = 1'b1;
                rd_issue_d      = 1'b1;
                rd_err_d        = !in_range(addr_q);
                addr_d          = addr_q + 1'b1;
                remaining_d     = remaining_q - 1'b1;
                if (remaining_q == BURST_WIDTH'(1)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, burst bookkeeping and the two-stage read-return pipeline.
    always_ff @(posedge Clk_400 or negedge SoftReset_n) begin
        if (!SoftReset_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            rd_issue_q  <= 1'b0;
            rd_err_q    <= 1'b0;
            rvalid_q    <= 1'b0;
            rdata_q     <= '0;
            resp_q      <= RESP_OKAY;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            rd_issue_q  <= rd_issue_d;
            rd_err_q    <= rd_err_d;
            rvalid_q    <= rd_issue_q;
            if (rd_issue_q) begin
                rdata_q <= rd_err_q ? '0 : ram_rdata;
                resp_q  <= rd_err_q ? RESP_DECODEERR : RESP_OKAY;
            end
        end
    end

    avmm_mem_resp_ram #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .WIDTH      (64)
    ) u_ram (
        .clk_i   (Clk_400),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .wdata_i (ram_wdata),
        .raddr_i (ram_raddr),
        .rdata_o (ram_rdata)
    );

    assign avs_readdata      = rdata_q;
    assign avs_readdatavalid = rvalid_q;
    assign avs_response      = resp_q;
    assign busy              = (state_q != IDLE);

endmodule

// File: doc/avmm_mem_responder.md
Name: avmm_mem_responder

Overview:
- Avalon-MM slave memory model for the hello_mem AFU; the responder end of the avm_* master port driven by the AFU CSR block.
- Backs a 64-bit word-addressed on-chip RAM; serves single and burst reads/writes; flags out-of-range accesses.
- Used as a DDR stand-in for simulation and for on-FPGA loopback builds.

Parameters:
- DEPTH_LOG2, 10, RAM depth = 2**DEPTH_LOG2 64-bit words
- ADDR_WIDTH, 32, width of avs_address (word address)
- BURST_WIDTH, 12, width of avs_burstcount
- LFSR_SEED, 16'hACE1, backpressure LFSR seed (used only with the optional feature)

Ports:
- Clk_400  in  1  core clock; all logic synchronous to it
- SoftReset_n  in  1  asynchronous, active-low reset
- avs_address  in  ADDR_WIDTH  word address of the first beat
- avs_burstcount  in  BURST_WIDTH  beats in the burst; 0 is treated as 1
- avs_read  in  1  read command
- avs_write  in  1  write command/beat
- avs_writedata  in  64  write beat data
- avs_waitrequest  out  1  stall; the command/beat is not accepted while high
- avs_readdata  out  64  read beat data
- avs_readdatavalid  out  1  readdata/response valid
- avs_response  out  2  00 OKAY, 11 DECODEERROR (out of range)
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (SoftReset_n low, async): state=IDLE; avs_waitrequest=0, avs_readdatavalid=0, avs_readdata=0, avs_response=00, busy=0. RAM contents are not reset.
- Accept rule: a command/beat is accepted on a rising edge where (avs_read|avs_write) & !avs_waitrequest.
- In range: addr < 2**DEPTH_LOG2, evaluated per beat on the incremented address.
- States:
  - IDLE: waitrequest=0.
    - Write accepted: write beat 0 if in range (dropped otherwise). If burstcount>1, go to WR_BURST with remaining = burstcount-1 and addr+1.
    - Read accepted: latch addr and count; go to RD_BURST.
    - avs_read & avs_write together: write wins, read ignored.
  - WR_BURST: waitrequest=0.
    - Each accepted avs_write writes one beat at the current address, then address +1 and remaining -1. Go to IDLE after the last beat.
    - avs_read is ignored. Gaps (avs_write low) are allowed indefinitely.
  - RD_BURST: waitrequest=1.
    - Issue one RAM read per cycle; beat k's avs_readdatavalid is asserted at edge T+2+k, where T is the accept edge. No gaps.
    - Per-beat response: 00, or 11 for out-of-range beats (readdata=0 on those beats).
    - Go to IDLE when the last RAM read issues; waitrequest drops that same cycle, so a new command can be accepted while the last 1–2 beats drain.
- RAM: synchronous 1-cycle read; a write and a read to the same address in the same cycle return old data.
- Address arithmetic: ADDR_WIDTH wide, wraps at 2**ADDR_WIDTH. There is no wrap at RAM depth; beats past the depth are errored.
- A reset asserted mid-burst aborts the burst immediately. Any pending readdatavalid is squashed; writes already committed remain.

Optional Feature:
- AVMM_MEM_RESP_BACKPRESSURE_EN defined: a 16-bit Fibonacci LFSR (taps 16,14,13,11; seeded with LFSR_SEED on reset) advances every cycle. In IDLE and WR_BURST, avs_waitrequest = lfsr[0], so roughly 50% random stall. Read data timing is unchanged once a read is accepted.
- Not defined: the LFSR is absent and waitrequest is exactly as described above.

Decomposition:
- Package avmm_mem_resp_pkg holds:
  - RESP_OKAY=2'b00 and RESP_DECODEERR=2'b11
  - state enum t_resp_state {IDLE, WR_BURST, RD_BURST}
  - LFSR tap constant
- Sub-module avmm_mem_resp_ram: parameterised single-clock 1W/1R synchronous RAM (DEPTH_LOG2, 64-bit).

Test Plan:
- Single write addr=0x10, data=0xDEADBEEF_CAFEF00D, burstcount=1; then read addr=0x10 -> one readdatavalid 2 cycles after accept, readdata=0xDEADBEEF_CAFEF00D, response=00.
- Write burst addr=0x20, burstcount=4, data 1..4 with 2-cycle gaps between beats; read burst addr=0x20, burstcount=4 -> 4 consecutive valids with data 1,2,3,4; waitrequest high 4 cycles.
- Read burst addr=0x3FE, burstcount=4, DEPTH_LOG2=10 -> responses 00,00,11,11; readdata=0 on beats 3–4.
- avs_read=avs_write=1 at addr 0x5, data=0x77 -> write performed, no readdatavalid; a subsequent read returns 0x77.
- Assert SoftReset_n low during the 3rd beat of an 8-beat read -> readdatavalid=0 the same cycle, busy=0, state IDLE; a post-reset read of a previously written word returns intact data.
- With AVMM_MEM_RESP_BACKPRESSURE_EN: 64 single writes held until accepted, then read back -> all data match; waitrequest observed high at least once.
